// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default constants
package uart_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} uart_tx_state_t;

  localparam int UART_CLK_DIV   = 868;
  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - reloadable bit-period down-counter, tick while count is zero
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD_VAL = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == '0);

  // Reaching zero while running starts the next bit period immediately.
  always_comb begin
    cnt_d = cnt_q;
    if (reload || (run && tick)) begin
      cnt_d = RELOAD_VAL;
    end else if (run) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter draining a non-FWFT FIFO
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = UART_CLK_DIV,
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_dout,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_tx_state_t       state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 stop_last;
  logic                 baud_reload, baud_run, baud_tick;

  assign fifo_rd_en  = (state_q == IDLE) & en & ~fifo_empty & rst_n;
  assign tx          = tx_q;
  assign busy        = (state_q != IDLE);
  assign baud_reload = (state_q == LOAD);
  assign baud_run    = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign stop_last   = (STOP_BITS == 1) || stop_cnt_q;

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .reload(baud_reload),
    .run   (baud_run),
    .tick  (baud_tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_rd_en) state_d = LOAD;
      end
      // FIFO read data is valid only in the cycle after the pop.
      LOAD: begin
        shift_d = fifo_dout;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (idx_q == LAST_IDX) begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_last) state_d = IDLE;
          else           stop_cnt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assert property (@(posedge clk) fifo_rd_en |-> !fifo_empty);
  assert property (@(posedge clk) state_q inside {IDLE, LOAD, START, DATA, STOP});

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed scoreboard bench for uart_tx_fifo with behavioural FIFOs
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n0, rst_n1, en0, en1;
  logic       empty0, empty1, rd0, rd1, tx0, tx1, busy0, busy1;
  logic [7:0] dout0 = '0, dout1 = '0;
  logic [7:0] mem0 [8];
  logic [7:0] mem1 [8];
  logic [3:0] wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;
  int         rdcnt0 = 0, rdcnt1 = 0;
  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];
  int         checks = 0, errors = 0;

  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);

  always @(posedge clk) begin
    if (rd0) begin
      dout0  <= mem0[rp0[2:0]];
      rp0    <= rp0 + 4'd1;
      rdcnt0 <= rdcnt0 + 1;
    end
    if (rd1) begin
      dout1  <= mem1[rp1[2:0]];
      rp1    <= rp1 + 4'd1;
      rdcnt1 <= rdcnt1 + 1;
    end
  end

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n0), .en(en0), .fifo_empty(empty0), .fifo_dout(dout0),
    .fifo_rd_en(rd0), .tx(tx0), .busy(busy0)
  );

  uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(8), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n1), .en(en1), .fifo_empty(empty1), .fifo_dout(dout1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx0 : tx1;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  task automatic push(input int sel, input logic [7:0] b);
    if (sel == 0) begin
      mem0[wp0[2:0]] = b;
      wp0 = wp0 + 4'd1;
      sb0.push_back(b);
    end else begin
      mem1[wp1[2:0]] = b;
      wp1 = wp1 + 4'd1;
      sb1.push_back(b);
    end
  endtask

  // Returns at the negedge holding the first low sample of the start bit.
  task automatic wait_start(input int sel, input int max, output int highs);
    highs = 0;
    @(negedge clk);
    while (tx_of(sel) !== 1'b0 && highs < max) begin
      highs++;
      @(negedge clk);
    end
    chk("start_seen", tx_of(sel), 1'b0);
  endtask

  task automatic quiet(input string tag, input int n);
    logic bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || rd0 !== 1'b0) bad = 1'b1;
    end
    chk(tag, bad, 1'b0);
  endtask

  // Samples every cycle of the frame; each bit must hold for exactly div cycles.
  task automatic recv(input int sel, input int div, input int stops, input int gap_exp,
                      input int kill_at, output logic [11:0] bits);
    int         highs;
    int         nbits;
    logic       ok;
    logic [7:0] exp;
    wait_start(sel, 400, highs);
    if (gap_exp >= 0) chk("gap", highs, gap_exp);
    nbits = 1 + 8 + stops;
    ok    = 1'b1;
    bits  = '0;
    for (int k = 0; k < nbits * div; k++) begin
      if (k > 0) @(negedge clk);
      if (k == kill_at) begin
        if (sel == 0) en0 = 1'b0;
        else          en1 = 1'b0;
      end
      if (k % div == 0) bits[k / div] = tx_of(sel);
      else if (tx_of(sel) !== bits[k / div]) ok = 1'b0;
      if (busy_of(sel) !== 1'b1) ok = 1'b0;
    end
    chk("bit_width_busy", ok, 1'b1);
    chk("start_bit", bits[0], 1'b0);
    chk("stop_bits", (stops == 2) ? {bits[10], bits[9]} : {1'b1, bits[9]}, 2'b11);
    exp = 'x;
    if (sel == 0) begin
      if (sb0.size() > 0) exp = sb0.pop_front();
    end else begin
      if (sb1.size() > 0) exp = sb1.pop_front();
    end
    chk("data", bits[8:1], exp);
  endtask

  initial begin
    logic [11:0] fb;
    int          r0;
    int          h;

    rst_n0 = 1'b0; rst_n1 = 1'b0; en0 = 1'b1; en1 = 1'b0;
    push(0, 8'hA5);
    repeat (3) @(negedge clk);
    chk("rst_tx", tx0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_rd_en", rd0, 1'b0);
    chk("rst_state", u0.state_q, IDLE);
    chk("rst_tx_b", tx1, 1'b1);

    // single 0xA5 frame
    r0 = rdcnt0;
    rst_n0 = 1'b1;
    recv(0, 4, 1, -1, -1, fb);
    chk("a5_bits", fb[9:0], {1'b1, 8'hA5, 1'b0});
    @(negedge clk);
    chk("a5_idle_busy", busy0, 1'b0);
    chk("a5_idle_tx", tx0, 1'b1);
    chk("a5_pops", rdcnt0 - r0, 1);
    chk("a5_empty", empty0, 1'b1);

    // back-to-back frames
    r0 = rdcnt0;
    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
    for (int i = 0; i < 3; i++) recv(0, 4, 1, (i == 0) ? -1 : 2, -1, fb);
    chk("b2b_pops", rdcnt0 - r0, 3);

    // disabled with data queued, then enabled
    en0 = 1'b0;
    r0 = rdcnt0;
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
    quiet("en_off_quiet", 100);
    chk("en_off_pops", rdcnt0 - r0, 0);
    en0 = 1'b1;
    for (int i = 0; i < 4; i++) recv(0, 4, 1, (i == 0) ? -1 : 2, -1, fb);
    chk("en_on_pops", rdcnt0 - r0, 4);

    // enable dropped in the middle of frame 2 of 4
    r0 = rdcnt0;
    push(0, 8'h55); push(0, 8'h66); push(0, 8'h77); push(0, 8'h88);
    recv(0, 4, 1, -1, -1, fb);
    recv(0, 4, 1, 2, 20, fb);
    quiet("en_drop_quiet", 60);
    chk("en_drop_pops", rdcnt0 - r0, 2);
    chk("en_drop_level", wp0 - rp0, 4'd2);
    en0 = 1'b1;
    for (int i = 0; i < 2; i++) recv(0, 4, 1, (i == 0) ? -1 : 2, -1, fb);

    // reset pulse during DATA discards the popped byte
    push(0, 8'h5A); push(0, 8'hC3);
    wait_start(0, 400, h);
    repeat (12) @(negedge clk);
    rst_n0 = 1'b0;
    @(negedge clk);
    chk("midrst_tx", tx0, 1'b1);
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_state", u0.state_q, IDLE);
    chk("midrst_rd_en", rd0, 1'b0);
    rst_n0 = 1'b1;
    void'(sb0.pop_front());
    recv(0, 4, 1, -1, -1, fb);
    chk("midrst_empty", empty0, 1'b1);

    // two stop bits, CLK_DIV=3
    rst_n1 = 1'b1;
    en1 = 1'b1;
    push(1, 8'h81);
    recv(1, 3, 2, -1, -1, fb);
    chk("stop2_bits", fb[10:0], {2'b11, 8'h81, 1'b0});
    @(negedge clk);
    chk("stop2_end_busy", busy1, 1'b0);
    chk("stop2_pops", rdcnt1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
